// File: rtl/jcpu_pkg.sv
// jcpu_pkg
// Shared definitions for the control-sequencing stage.
//   jphase_e      : encoding of the four wclk phases of one CPU cycle
//   JNSTEPS_DEF   : default number of one-hot steps per instruction
//   JPH_*_MAP     : per-phase strobe values, indexed by the phase encoding
// Optional build macro used by the stepper: JSTEPPER_SINGLE_STEP_EN.
package jcpu_pkg;

  typedef enum logic [1:0] {
    JPH_P0 = 2'd0,
    JPH_P1 = 2'd1,
    JPH_P2 = 2'd2,
    JPH_P3 = 2'd3
  } jphase_e;

  localparam int JNSTEPS_DEF = 7;

  // Bit n gives the strobe level while the phase counter sits in phase n.
  // wclks is only set in P2, so it is always nested strictly inside wclke.
  localparam logic [3:0] JPH_WCLKE_MAP = 4'b1110;
  localparam logic [3:0] JPH_WCLKS_MAP = 4'b0100;

endpackage

// File: rtl/jstepper_if.sv
// jstepper_if
// Bundles the stepper's control inputs and step/strobe outputs.
//   wrun, wrestart         : run enable and early-return request (master -> slave)
//   bos, wlast             : one-hot step and last-step flag (slave -> master)
//   wclke, wclks, wbusy    : phase strobes and cycle-in-progress flag
//   wstep_req, wstep_ack   : single-step handshake, only with JSTEPPER_SINGLE_STEP_EN
// Modports: master (control section / bench), slave (jstepper).
interface jstepper_if import jcpu_pkg::*; #(
  parameter int NSTEPS = JNSTEPS_DEF
);

  logic              wrun;
  logic              wrestart;
  logic [NSTEPS-1:0] bos;
  logic              wclke;
  logic              wclks;
  logic              wlast;
  logic              wbusy;
`ifdef JSTEPPER_SINGLE_STEP_EN
  logic              wstep_req;
  logic              wstep_ack;

  modport master (
    output wrun, wrestart, wstep_req,
    input  bos, wclke, wclks, wlast, wbusy, wstep_ack
  );

  modport slave (
    input  wrun, wrestart, wstep_req,
    output bos, wclke, wclks, wlast, wbusy, wstep_ack
  );
`else
  modport master (
    output wrun, wrestart,
    input  bos, wclke, wclks, wlast, wbusy
  );

  modport slave (
    input  wrun, wrestart,
    output bos, wclke, wclks, wlast, wbusy
  );
`endif

endinterface

// File: rtl/jphase_gen.sv
// jphase_gen
// Four-phase generator: splits each CPU cycle into P0..P3 of the clock.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_req    : begin a new cycle when idle in P0
//   phase        : current phase
//   wclke, wclks : registered enable / set strobes
//   wbusy        : registered cycle-in-progress flag
//   cycle_start  : high in P0 when the next edge starts a cycle
//   cycle_end    : high in P3, i.e. the next edge closes the cycle
module jphase_gen import jcpu_pkg::*; (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    start_req,
  output jphase_e phase,
  output logic    wclke,
  output logic    wclks,
  output logic    wbusy,
  output logic    cycle_start,
  output logic    cycle_end
);

  jphase_e phase_q, phase_d;
  logic    wclke_q, wclke_d;
  logic    wclks_q, wclks_d;
  logic    wbusy_q, wbusy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= JPH_P0;
      wclke_q <= 1'b0;
      wclks_q <= 1'b0;
      wbusy_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      wclke_q <= wclke_d;
      wclks_q <= wclks_d;
      wbusy_q <= wbusy_d;
    end
  end

  // Only P0 waits; once started a cycle always runs to completion.
  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      JPH_P0: if (start_req) phase_d = JPH_P1;
      JPH_P1: phase_d = JPH_P2;
      JPH_P2: phase_d = JPH_P3;
      JPH_P3: phase_d = JPH_P0;
    endcase
  end

  // Strobes are registered from the next phase so they line up with phase_q.
  always_comb begin
    wclke_d     = JPH_WCLKE_MAP[phase_d];
    wclks_d     = JPH_WCLKS_MAP[phase_d];
    wbusy_d     = (phase_d != JPH_P0);
    cycle_start = (phase_q == JPH_P0) && start_req;
    cycle_end   = (phase_q == JPH_P3);
  end

  assign phase = phase_q;
  assign wclke = wclke_q;
  assign wclks = wclks_q;
  assign wbusy = wbusy_q;

endmodule

// File: rtl/jstepper.sv
// jstepper
// One-hot instruction step ring advanced once per four-phase CPU cycle.
//   wclk, wrst_n : clock, asynchronous active-low reset
//   js (slave)   : wrun, wrestart in; bos, wclke, wclks, wlast, wbusy out
// Parameter NSTEPS (3..16): steps per instruction; step NSTEPS-1 wraps.
// Build macro JSTEPPER_SINGLE_STEP_EN: wrun is ignored and each rising
// wstep_req starts exactly one CPU cycle, acknowledged by a wstep_ack pulse.
module jstepper import jcpu_pkg::*; #(
  parameter int NSTEPS = JNSTEPS_DEF
) (
  input  logic       wclk,
  input  logic       wrst_n,
  jstepper_if.slave  js
);

  localparam logic [NSTEPS-1:0] BOS_STEP0 = {{(NSTEPS-1){1'b0}}, 1'b1};

  jphase_e           phase;
  logic              start_req;
  logic              cycle_start;
  logic              cycle_end;
  logic              wclke, wclks, wbusy;

  logic [NSTEPS-1:0] bos_q, bos_d;
  logic              wlast_q, wlast_d;
  logic              restart_q, restart_d;

  jphase_gen u_phase (
    .clk         (wclk),
    .rst_n       (wrst_n),
    .start_req   (start_req),
    .phase       (phase),
    .wclke       (wclke),
    .wclks       (wclks),
    .wbusy       (wbusy),
    .cycle_start (cycle_start),
    .cycle_end   (cycle_end)
  );

`ifdef JSTEPPER_SINGLE_STEP_EN
  logic armed_q, armed_d;
  logic ack_q, ack_d;
  logic unused_wrun;

  assign unused_wrun = js.wrun;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      armed_q <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      armed_q <= armed_d;
      ack_q   <= ack_d;
    end
  end

  // A request must be seen low before it can start another cycle, so a
  // held request produces exactly one CPU cycle.
  always_comb begin
    start_req = js.wstep_req && armed_q;
    armed_d   = armed_q;
    if (!js.wstep_req)
      armed_d = 1'b1;
    else if (cycle_start)
      armed_d = 1'b0;
    ack_d = cycle_end;
  end

  assign js.wstep_ack = ack_q;
`else
  assign start_req = js.wrun;
`endif

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      bos_q     <= BOS_STEP0;
      wlast_q   <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      bos_q     <= bos_d;
      wlast_q   <= wlast_d;
      restart_q <= restart_d;
    end
  end

  // Restart requests are held until the cycle closes; a request in an idle
  // P0 (no cycle starting) is dropped.
  always_comb begin
    restart_d = restart_q;
    if (cycle_end)
      restart_d = 1'b0;
    else if (js.wrestart && ((phase != JPH_P0) || cycle_start))
      restart_d = 1'b1;

    bos_d = bos_q;
    if (cycle_end) begin
      if (restart_q || js.wrestart || bos_q[NSTEPS-1])
        bos_d = BOS_STEP0;
      else
        bos_d = {bos_q[NSTEPS-2:0], 1'b0};
    end

    wlast_d = bos_d[NSTEPS-1];
  end

  assign js.bos   = bos_q;
  assign js.wlast = wlast_q;
  assign js.wclke = wclke;
  assign js.wclks = wclks;
  assign js.wbusy = wbusy;

endmodule

// File: tb/tb_jstepper.sv
`timescale 1ns/1ps
// tb_jstepper
// Self-checking bench for jstepper. A behavioural model tracks phase number,
// step index and the pending restart with plain integers; expected outputs
// are derived from those. A NSTEPS=3 instance checks the short-ring wrap.
module tb_jstepper;
  import jcpu_pkg::*;

  localparam int N = 7;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;
  logic rst3_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int m_phase;
  int m_step;
  bit m_latch;
  bit m_armed;
  bit m_ack;

  typedef struct {
    bit         run;
    bit         restart;
    logic [6:0] bos;
    bit         wclke;
    bit         wclks;
  } vec_t;

  vec_t vecs[14];

  // Free-running clock shared by both instances
  always #5 wclk = ~wclk;

  jstepper_if #(.NSTEPS(N)) js ();
  jstepper_if #(.NSTEPS(3)) js3 ();

  jstepper #(.NSTEPS(N)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .js     (js)
  );

  jstepper #(.NSTEPS(3)) dut3 (
    .wclk   (wclk),
    .wrst_n (rst3_n),
    .js     (js3)
  );

  // One comparison: counts it and reports a FAIL line on mismatch
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model reset: idle in phase 0 at step 0, nothing pending
  task automatic model_reset();
    m_phase = 0;
    m_step  = 0;
    m_latch = 0;
    m_armed = 1;
    m_ack   = 0;
  endtask

  // Model of one clock edge, written from the cycle rules directly
  task automatic model_edge(input bit run, input bit restart, input bit req);
    bit start;
    start = 0;
    m_ack = 0;
    if (m_phase == 0) begin
`ifdef JSTEPPER_SINGLE_STEP_EN
      start = req && m_armed;
`else
      start = run;
`endif
      if (start) begin
        m_phase = 1;
        if (restart) m_latch = 1;
      end
    end else if (m_phase < 3) begin
      m_phase = m_phase + 1;
      if (restart) m_latch = 1;
    end else begin
      m_phase = 0;
      m_ack   = 1;
      if (m_latch || restart || m_step == N - 1) m_step = 0;
      else m_step = m_step + 1;
      m_latch = 0;
    end
    if (!req) m_armed = 1;
    else if (start) m_armed = 0;
  endtask

  // Drive inputs, advance model and DUT by one clock, settle after the edge
  task automatic applyStimulus(input bit run, input bit restart, input bit req);
    js.wrun     = run;
    js.wrestart = restart;
`ifdef JSTEPPER_SINGLE_STEP_EN
    js.wstep_req = req;
`endif
    model_edge(run, restart, req);
    @(posedge wclk);
    #1;
  endtask

  // Compare every output of the main instance against the model
  task automatic checkOutput(input string name);
    logic [N-1:0] exp_bos;
    exp_bos = N'(1) << m_step;
    cmp({name, " bos"},    32'(js.bos), 32'(exp_bos));
    cmp({name, " wclke"},  32'(js.wclke), 32'(m_phase != 0));
    cmp({name, " wclks"},  32'(js.wclks), 32'(m_phase == 2));
    cmp({name, " wbusy"},  32'(js.wbusy), 32'(m_phase != 0));
    cmp({name, " wlast"},  32'(js.wlast), 32'(m_step == N - 1));
    cmp({name, " onehot"}, 32'($onehot(js.bos)), 32'd1);
    cmp({name, " nest"},   32'(js.wclks & ~js.wclke), 32'd0);
`ifdef JSTEPPER_SINGLE_STEP_EN
    cmp({name, " ack"},    32'(js.wstep_ack), 32'(m_ack));
`endif
  endtask

  // Hold reset for two clocks and release just after an edge
  task automatic do_reset();
    wrst_n      = 1'b0;
    js.wrun     = 1'b0;
    js.wrestart = 1'b0;
`ifdef JSTEPPER_SINGLE_STEP_EN
    js.wstep_req = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  // Main test sequence
  initial begin
    int sclk_cnt;
    int last_cnt;
    int ack_cnt;
    bit run_r;
    bit req_r;
    int step3;

    js3.wrun     = 1'b1;
    js3.wrestart = 1'b0;
`ifdef JSTEPPER_SINGLE_STEP_EN
    js3.wstep_req = 1'b0;
`endif

    // Hand-derived vectors: start, mid-cycle run drop, restart latched at
    // the starting P0, and a restart pulse in an idle P0 that must be ignored.
    vecs[0]  = '{1, 0, 7'h01, 1, 0};
    vecs[1]  = '{1, 0, 7'h01, 1, 1};
    vecs[2]  = '{0, 0, 7'h01, 1, 0};
    vecs[3]  = '{0, 0, 7'h02, 0, 0};
    vecs[4]  = '{0, 0, 7'h02, 0, 0};
    vecs[5]  = '{1, 1, 7'h02, 1, 0};
    vecs[6]  = '{1, 0, 7'h02, 1, 1};
    vecs[7]  = '{1, 0, 7'h02, 1, 0};
    vecs[8]  = '{1, 0, 7'h01, 0, 0};
    vecs[9]  = '{0, 1, 7'h01, 0, 0};
    vecs[10] = '{1, 0, 7'h01, 1, 0};
    vecs[11] = '{1, 0, 7'h01, 1, 1};
    vecs[12] = '{1, 0, 7'h01, 1, 0};
    vecs[13] = '{1, 0, 7'h02, 0, 0};

    // Reset values while reset is held
    wrst_n = 1'b0;
    js.wrun = 1'b0;
    js.wrestart = 1'b0;
`ifdef JSTEPPER_SINGLE_STEP_EN
    js.wstep_req = 1'b0;
`endif
    #12;
    cmp("reset bos",   32'(js.bos), 32'h01);
    cmp("reset wclke", 32'(js.wclke), 32'd0);
    cmp("reset wclks", 32'(js.wclks), 32'd0);
    cmp("reset wlast", 32'(js.wlast), 32'd0);
    cmp("reset wbusy", 32'(js.wbusy), 32'd0);

`ifndef JSTEPPER_SINGLE_STEP_EN
    // Table-driven vectors
    do_reset();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].run, vecs[i].restart, 1'b0);
      cmp($sformatf("vec%0d bos", i),   32'(js.bos),   32'(vecs[i].bos));
      cmp($sformatf("vec%0d wclke", i), 32'(js.wclke), 32'(vecs[i].wclke));
      cmp($sformatf("vec%0d wclks", i), 32'(js.wclks), 32'(vecs[i].wclks));
    end

    // Full instruction: 28 clocks walk 0x01..0x40 and wrap to 0x01
    do_reset();
    sclk_cnt = 0;
    last_cnt = 0;
    for (int k = 0; k < 28; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("run28");
      if (js.wclks) sclk_cnt++;
      if (js.wlast) last_cnt++;
    end
    cmp("run28 wclks count", 32'(sclk_cnt), 32'd7);
    cmp("run28 wlast count", 32'(last_cnt), 32'd4);
    cmp("run28 wrap bos",    32'(js.bos), 32'h01);

    // wrun drops at P1 of step 2: cycle completes, ring parks on step 3
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("drop pre");
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("drop hold");
    end
    cmp("drop bos",   32'(js.bos), 32'h08);
    cmp("drop wclke", 32'(js.wclke), 32'd0);
    cmp("drop wbusy", 32'(js.wbusy), 32'd0);

    // One-clock restart pulse at P1 of step 3 returns to step 0, not step 4
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("restart p2");
    applyStimulus(1'b1, 1'b0, 1'b0);
    cmp("restart mid bos", 32'(js.bos), 32'h08);
    applyStimulus(1'b1, 1'b0, 1'b0);
    cmp("restart bos", 32'(js.bos), 32'h01);

    // Asynchronous reset at P2 of step 5
    for (int k = 0; k < 22; k++) applyStimulus(1'b1, 1'b0, 1'b0);
    cmp("prerst bos",   32'(js.bos), 32'h20);
    cmp("prerst wclks", 32'(js.wclks), 32'd1);
    wrst_n = 1'b0;
    #1;
    cmp("async wclks", 32'(js.wclks), 32'd0);
    cmp("async wclke", 32'(js.wclke), 32'd0);
    cmp("async bos",   32'(js.bos), 32'h01);
    cmp("async wbusy", 32'(js.wbusy), 32'd0);
    model_reset();
    #1;
    wrst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    cmp("postrst clk1 wclks", 32'(js.wclks), 32'd0);
    cmp("postrst clk1 wclke", 32'(js.wclke), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    cmp("postrst clk2 wclks", 32'(js.wclks), 32'd1);

    // NSTEPS=3 instance: after k edges with run held, step = (k/4) mod 3
    @(posedge wclk);
    #1;
    rst3_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge wclk);
      #1;
      step3 = (k / 4) % 3;
      cmp($sformatf("n3 k%0d bos", k),   32'(js3.bos), 32'(1 << step3));
      cmp($sformatf("n3 k%0d wlast", k), 32'(js3.wlast), 32'(step3 == 2));
    end
`else
    // Held request: exactly one step advance and one acknowledge
    do_reset();
    ack_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("ss held");
      if (js.wstep_ack) ack_cnt++;
    end
    cmp("ss held bos",  32'(js.bos), 32'h02);
    cmp("ss held acks", 32'(ack_cnt), 32'd1);
    // Release and re-assert: one more step
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("ss again");
      if (js.wstep_ack) ack_cnt++;
    end
    cmp("ss again bos",  32'(js.bos), 32'h04);
    cmp("ss again acks", 32'(ack_cnt), 32'd2);
`endif

    // Randomized run / restart / request against the model
    do_reset();
    run_r = 1'b1;
    req_r = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) run_r = ~run_r;
      if ($urandom_range(0, 5) == 0) req_r = ~req_r;
      applyStimulus(run_r, ($urandom_range(0, 9) == 0), req_r);
      checkOutput($sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
